// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared widths, FSM encoding and operand-pair type for the MAC scheduler.
// No logic; latency and backpressure are not applicable.
package mac_sched_pkg;
  localparam int RES_W = 16;
  localparam int OP_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } pair_t;

  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/mac_sched_if.sv
// mac_sched_if: requester, MAC and result signals of the scheduler; master = environment, slave = scheduler.
// Pure wiring: no latency; rdy/vld carries the operand backpressure.
interface mac_sched_if #(parameter int LEN_W = 4);
  import mac_sched_pkg::*;

  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [OP_W-1:0]  a0;
  logic [OP_W-1:0]  b0;
  logic [OP_W-1:0]  a1;
  logic [OP_W-1:0]  b1;
  logic [1:0]       vld;
  logic [1:0]       rdy;
  logic [1:0]       gnt;
  logic [OP_W-1:0]  mac_ina;
  logic [OP_W-1:0]  mac_inb;
  logic             mac_clr;
  logic [RES_W-1:0] mac_out;
  logic [RES_W-1:0] res;
  logic             res_vld;
  logic             res_id;

  modport master (
    output req, len0, len1, a0, b0, a1, b1, vld, mac_out,
    input  rdy, gnt, mac_ina, mac_inb, mac_clr, res, res_vld, res_id
  );

  modport slave (
    input  req, len0, len1, a0, b0, a1, b1, vld, mac_out,
    output rdy, gnt, mac_ina, mac_inb, mac_clr, res, res_vld, res_id
  );
endinterface

// File: rtl/mac_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; combinational one-hot grant from req and a priority pointer.
// Zero latency; pointer moves only on adv, so a held grant is never disturbed.
module rr_arb2
  import mac_sched_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       adv_id,
  output logic [1:0] gnt
);
  // ptr_q names the requester that currently has priority
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv) ptr_d = ~adv_id;
  end

  always_ff @(posedge clk) begin
    if (clr) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    gnt = 2'b00;
    if (req[ptr_q])       gnt = onehot2(ptr_q);
    else if (req[~ptr_q]) gnt = onehot2(~ptr_q);
  end
endmodule

// File: rtl/mac_sched.sv
// mac_sched: round-robin scheduler streaming one requester's operand pairs into a shared MAC.
// Result N+2 cycles after grant with no stalls; vld-low stalls RUN indefinitely, other requester waits on req.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic        clk,
  input  logic        clr,
  mac_sched_if.slave  bus
);
  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             res_id_q, res_id_d;
  logic [1:0]       arb_gnt;
  logic             adv;
  logic             beat;
  pair_t            sel;

  rr_arb2 u_arb (
    .clk    (clk),
    .clr    (clr),
    .req    (bus.req),
    .adv    (adv),
    .adv_id (id_q),
    .gnt    (arb_gnt)
  );

  always_comb begin
    sel = id_q ? {bus.a1, bus.b1} : {bus.a0, bus.b0};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    adv         = 1'b0;
    beat        = 1'b0;
    bus.rdy     = 2'b00;
    bus.gnt     = 2'b00;
    bus.mac_clr = 1'b0;
    bus.mac_ina = '0;
    bus.mac_inb = '0;
    bus.res_vld = 1'b0;
    bus.res     = res_q;
    bus.res_id  = res_id_q;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          id_d    = arb_gnt[1];
          cnt_d   = arb_gnt[1] ? bus.len1 : bus.len0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        bus.gnt     = onehot2(id_q);
        bus.mac_clr = 1'b1;
        state_d     = (cnt_q == '0) ? DONE : RUN;
      end
      RUN: begin
        bus.gnt = onehot2(id_q);
        bus.rdy = onehot2(id_q);
        beat    = bus.vld[id_q];
        // Operands stay zero between beats so the free-running MAC holds its sum
        if (beat) begin
          bus.mac_ina = sel.a;
          bus.mac_inb = sel.b;
          cnt_d       = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        bus.gnt     = onehot2(id_q);
        bus.res_vld = 1'b1;
        bus.res     = bus.mac_out;
        bus.res_id  = id_q;
        res_d       = bus.mac_out;
        res_id_d    = id_q;
        adv         = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      id_q     <= 1'b0;
      res_q    <= '0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
    end
  end
endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: drives both requesters and a MAC model, compares results against arithmetic dot products.
module tb_mac_sched;
  import mac_sched_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  mac_sched_if #(.LEN_W(4)) bus ();

  mac_sched #(.LEN_W(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // External MAC: accumulates every clock; deliberately not reset so stale sums would show
  logic [15:0] acc = 16'h5a5a;
  always @(posedge clk)
    acc <= bus.mac_clr ? 16'h0000 : acc + ({8'h00, bus.mac_ina} * {8'h00, bus.mac_inb});
  assign bus.mac_out = acc;

  int n_chk = 0;
  int n_fail = 0;

  bit         active[2];
  int         L[2];
  logic [7:0] pa[2][16];
  logic [7:0] pb[2][16];
  bit         vp[2][64];
  bit         vrand;
  int         prio;

  int          nres;
  logic [15:0] r_res[4];
  int          r_id[4];
  int          r_cyc[4];
  int          clr_cyc;
  int          beats[2];
  int          rdy_cyc[2];
  int          op_err;
  bit          timed_out;

  function automatic logic [15:0] exp_sum(input int i);
    int s = 0;
    for (int j = 0; j < L[i]; j++) s = s + int'(pa[i][j]) * int'(pb[i][j]);
    return 16'(s);
  endfunction

  task automatic clear_ops();
    active[0] = 0; active[1] = 0; vrand = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) vp[i][j] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1; bus.req = 2'b00; bus.vld = 2'b00;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    prio = 0;
  endtask

  // Cycle driver: k=0 is the IDLE cycle where req is first presented. Records, never judges.
  task automatic run(input int budget, input int abort_at);
    int ptr[2];
    int vidx[2];
    int k;
    bit v;
    bit any_beat;
    ptr[0] = 0; ptr[1] = 0; vidx[0] = 0; vidx[1] = 0;
    nres = 0; clr_cyc = -1; op_err = 0; timed_out = 0;
    beats[0] = 0; beats[1] = 0; rdy_cyc[0] = 0; rdy_cyc[1] = 0;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (k == abort_at) begin
        clr = 1'b1; bus.req = 2'b00; bus.vld = 2'b00;
        @(negedge clk);
        clr = 1'b0;
        return;
      end
      bus.req = {active[1], active[0]};
      #1;
      for (int i = 0; i < 2; i++) begin
        if (bus.rdy[i]) begin
          rdy_cyc[i]++;
          v = vrand ? ($urandom_range(0, 9) < 7) : (vidx[i] < 64 ? vp[i][vidx[i]] : 1'b1);
          vidx[i]++;
        end else begin
          v = 1'($urandom_range(0, 1));
        end
        bus.vld[i] = v;
        if (i == 0) begin
          bus.len0 = bus.gnt[0] ? 4'($urandom) : 4'(L[0]);
          bus.a0 = (v && bus.rdy[0] && ptr[0] < 16) ? pa[0][ptr[0]] : 8'($urandom);
          bus.b0 = (v && bus.rdy[0] && ptr[0] < 16) ? pb[0][ptr[0]] : 8'($urandom);
        end else begin
          bus.len1 = bus.gnt[1] ? 4'($urandom) : 4'(L[1]);
          bus.a1 = (v && bus.rdy[1] && ptr[1] < 16) ? pa[1][ptr[1]] : 8'($urandom);
          bus.b1 = (v && bus.rdy[1] && ptr[1] < 16) ? pb[1][ptr[1]] : 8'($urandom);
        end
      end
      #1;
      any_beat = 0;
      for (int i = 0; i < 2; i++) begin
        if (bus.vld[i] && bus.rdy[i]) begin
          any_beat = 1;
          if (ptr[i] >= 16 || bus.mac_ina !== pa[i][ptr[i]] || bus.mac_inb !== pb[i][ptr[i]]) op_err++;
          ptr[i]++;
          beats[i]++;
        end
      end
      if (!any_beat && (bus.mac_ina !== 8'h00 || bus.mac_inb !== 8'h00)) op_err++;
      if (bus.rdy === 2'b11) op_err++;
      if (bus.mac_clr && clr_cyc < 0) clr_cyc = k;
      if (bus.res_vld === 1'b1) begin
        if (nres < 4) begin
          r_res[nres] = bus.res; r_id[nres] = int'(bus.res_id); r_cyc[nres] = k;
        end
        nres++;
        active[int'(bus.res_id)] = 0;
      end
      k++;
      if (!active[0] && !active[1]) break;
      if (k >= budget) begin timed_out = 1; break; end
    end
    bus.req = 2'b00; bus.vld = 2'b00;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({bus.gnt, bus.rdy, bus.mac_clr, bus.res_vld, bus.res_id} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b required 0", {bus.gnt, bus.rdy, bus.mac_clr, bus.res_vld, bus.res_id});
    end
    n_chk++;
    if (bus.res !== 16'h0000) begin n_fail++; $display("FAIL reset_res: got %h required 0000", bus.res); end
    n_chk++;
    if ({bus.mac_ina, bus.mac_inb} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_ops: got %h required 0000", {bus.mac_ina, bus.mac_inb});
    end
    clr = 1'b0;
    prio = 0;
  endtask

  task automatic test_single();
    clear_ops();
    active[0] = 1; L[0] = 2;
    pa[0][0] = 3; pb[0][0] = 4; pa[0][1] = 5; pb[0][1] = 6;
    run(100, -1);
    n_chk++;
    if (nres !== 1 || r_res[0] !== 16'h002A || r_id[0] !== 0) begin
      n_fail++; $display("FAIL single_res: got n=%0d res=%h id=%0d required n=1 res=002a id=0", nres, r_res[0], r_id[0]);
    end
    n_chk++;
    if (clr_cyc !== 1 || r_cyc[0] !== 4) begin
      n_fail++; $display("FAIL single_timing: got clr@%0d res@%0d required clr@1 res@4", clr_cyc, r_cyc[0]);
    end
    n_chk++;
    if (op_err !== 0 || beats[0] !== 2) begin
      n_fail++; $display("FAIL single_ops: got err=%0d beats=%0d required 0 and 2", op_err, beats[0]);
    end
    prio = 1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_ops();
    active[0] = 1; active[1] = 1; L[0] = 1; L[1] = 1;
    pa[0][0] = 2; pb[0][0] = 2; pa[1][0] = 7; pb[1][0] = 3;
    run(100, -1);
    n_chk++;
    if (nres !== 2 || r_id[0] !== 0 || r_res[0] !== 16'h0004) begin
      n_fail++; $display("FAIL rr_first: got n=%0d id=%0d res=%h required n=2 id=0 res=0004", nres, r_id[0], r_res[0]);
    end
    n_chk++;
    if (r_id[1] !== 1 || r_res[1] !== 16'h0015 || r_cyc[1] !== 7) begin
      n_fail++; $display("FAIL rr_second: got id=%0d res=%h @%0d required id=1 res=0015 @7", r_id[1], r_res[1], r_cyc[1]);
    end
    active[0] = 1; active[1] = 1;
    run(100, -1);
    n_chk++;
    if (r_id[0] !== 0 || r_id[1] !== 1) begin
      n_fail++; $display("FAIL rr_third: got order %0d,%0d required 0,1", r_id[0], r_id[1]);
    end
    prio = 0;
  endtask

  task automatic test_stall();
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    clear_ops();
    active[1] = 1; L[1] = 3;
    for (int j = 0; j < 3; j++) begin pa[1][j] = 8'(j + 1); pb[1][j] = 8'(j + 1); end
    for (int j = 0; j < 6; j++) vp[1][j] = pat[j];
    run(100, -1);
    n_chk++;
    if (nres !== 1 || r_res[0] !== 16'h000E || r_id[0] !== 1) begin
      n_fail++; $display("FAIL stall_res: got n=%0d res=%h id=%0d required n=1 res=000e id=1", nres, r_res[0], r_id[0]);
    end
    n_chk++;
    if (beats[1] !== 3 || op_err !== 0 || r_cyc[0] !== 8 || rdy_cyc[1] !== 6) begin
      n_fail++; $display("FAIL stall_beats: got beats=%0d err=%0d res@%0d rdy=%0d required 3 0 8 6", beats[1], op_err, r_cyc[0], rdy_cyc[1]);
    end
    prio = 0;
  endtask

  task automatic test_overflow();
    clear_ops();
    active[0] = 1; L[0] = 2;
    for (int j = 0; j < 2; j++) begin pa[0][j] = 8'hFF; pb[0][j] = 8'hFF; end
    run(100, -1);
    n_chk++;
    if (nres !== 1 || r_res[0] !== 16'hFC02 || op_err !== 0) begin
      n_fail++; $display("FAIL overflow: got n=%0d res=%h err=%0d required n=1 res=fc02 err=0", nres, r_res[0], op_err);
    end
    prio = 1;
  endtask

  task automatic test_len0();
    clear_ops();
    active[0] = 1; L[0] = 0;
    run(100, -1);
    n_chk++;
    if (nres !== 1 || r_res[0] !== 16'h0000 || r_cyc[0] !== 2 || clr_cyc !== 1) begin
      n_fail++; $display("FAIL len0_res: got n=%0d res=%h @%0d clr@%0d required 1 0000 @2 clr@1", nres, r_res[0], r_cyc[0], clr_cyc);
    end
    n_chk++;
    if (rdy_cyc[0] !== 0 || op_err !== 0) begin
      n_fail++; $display("FAIL len0_rdy: got rdy=%0d err=%0d required 0 0", rdy_cyc[0], op_err);
    end
    prio = 1;
  endtask

  task automatic test_reset_mid_run();
    clear_ops();
    active[0] = 1; L[0] = 1; pa[0][0] = 9; pb[0][0] = 9;
    run(100, -1);
    n_chk++;
    if (nres !== 1 || r_res[0] !== 16'h0051) begin
      n_fail++; $display("FAIL abort_pre: got n=%0d res=%h required 1 0051", nres, r_res[0]);
    end
    clear_ops();
    active[0] = 1; L[0] = 3;
    for (int j = 0; j < 3; j++) begin pa[0][j] = 10; pb[0][j] = 10; end
    run(100, 3);
    #1;
    n_chk++;
    if (beats[0] !== 1) begin n_fail++; $display("FAIL abort_beats: got %0d required 1", beats[0]); end
    n_chk++;
    if ({bus.gnt, bus.rdy, bus.mac_clr, bus.res_vld, bus.res_id} !== 7'b0 || bus.res !== 16'h0000 ||
        {bus.mac_ina, bus.mac_inb} !== 16'h0000) begin
      n_fail++; $display("FAIL abort_idle: got ctl=%b res=%h required 0 0000",
                         {bus.gnt, bus.rdy, bus.mac_clr, bus.res_vld, bus.res_id}, bus.res);
    end
    prio = 0;
    clear_ops();
    active[0] = 1; active[1] = 1; L[0] = 2; L[1] = 1;
    pa[0][0] = 1; pb[0][0] = 2; pa[0][1] = 3; pb[0][1] = 4; pa[1][0] = 6; pb[1][0] = 7;
    run(100, -1);
    n_chk++;
    if (nres !== 2 || r_id[0] !== 0 || r_res[0] !== 16'h000E || r_id[1] !== 1 || r_res[1] !== 16'h002A) begin
      n_fail++; $display("FAIL abort_fresh: got n=%0d %0d:%h %0d:%h required 2 0:000e 1:002a",
                         nres, r_id[0], r_res[0], r_id[1], r_res[1]);
    end
  endtask

  task automatic test_random();
    int first;
    int cnt;
    logic [15:0] e0, e1;
    for (int it = 0; it < 20; it++) begin
      clear_ops();
      vrand = 1;
      active[0] = 1'($urandom_range(0, 1));
      active[1] = 1'($urandom_range(0, 1));
      if (!active[0] && !active[1]) active[it % 2] = 1;
      for (int i = 0; i < 2; i++) begin
        L[i] = $urandom_range(0, 15);
        for (int j = 0; j < 16; j++) begin pa[i][j] = 8'($urandom); pb[i][j] = 8'($urandom); end
      end
      cnt = int'(active[0]) + int'(active[1]);
      if (cnt == 2) first = prio;
      else first = active[1] ? 1 : 0;
      e0 = exp_sum(first);
      e1 = exp_sum(1 - first);
      run(600, -1);
      n_chk++;
      if (nres !== cnt || timed_out !== 0) begin
        n_fail++; $display("FAIL rand_count it=%0d: got n=%0d timeout=%0d required n=%0d", it, nres, timed_out, cnt);
      end
      n_chk++;
      if (r_id[0] !== first || r_res[0] !== e0) begin
        n_fail++; $display("FAIL rand_first it=%0d: got %0d:%h required %0d:%h", it, r_id[0], r_res[0], first, e0);
      end
      if (cnt == 2) begin
        n_chk++;
        if (r_id[1] !== 1 - first || r_res[1] !== e1) begin
          n_fail++; $display("FAIL rand_second it=%0d: got %0d:%h required %0d:%h", it, r_id[1], r_res[1], 1 - first, e1);
        end
      end
      n_chk++;
      if (op_err !== 0) begin n_fail++; $display("FAIL rand_ops it=%0d: got err=%0d required 0", it, op_err); end
      if (cnt == 1) prio = 1 - first;
    end
  endtask

  initial begin
    bus.req = 2'b00; bus.vld = 2'b00;
    bus.len0 = '0; bus.len1 = '0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    clear_ops();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_len0();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/mac_sched.md
Name: mac_sched

Overview:
- Two-requester scheduler/sequencer that shares one external mult_acc datapath (8x8 multiply, 16-bit accumulator).
- Each requester asks for a dot product of LEN operand pairs.
- The scheduler arbitrates round-robin, clears the accumulator, streams the granted requester's operand pairs through a valid/ready handshake, then returns the 16-bit sum tagged with the requester id.
- Sits between the two software-visible operand sources and the shared MAC instance.

Parameters:
- LEN_W, 4, width of the vector-length field; max length 2**LEN_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- req  in  2  req[i] level request from requester i; held until its res_vld
- len0  in  LEN_W  pair count for requester 0, sampled at grant
- len1  in  LEN_W  pair count for requester 1, sampled at grant
- a0, b0  in  8 each  requester 0 operand pair
- a1, b1  in  8 each  requester 1 operand pair
- vld  in  2  vld[i]: requester i operand pair valid
- rdy  out  2  rdy[i]: scheduler accepts requester i pair this cycle
- gnt  out  2  one-hot grant, held from CLEAR through DONE
- mac_ina, mac_inb  out  8 each  operands to the MAC
- mac_clr  out  1  accumulator clear to the MAC
- mac_out  in  16  MAC accumulator value
- res  out  16  dot-product result
- res_vld  out  1  one-cycle result strobe
- res_id  out  1  requester index of res

Behaviour:
- FSM states: IDLE, CLEAR, RUN, DONE.
- Reset (clr=1 at an edge), from any state including mid-RUN:
  - state returns to IDLE; gnt=0, rdy=0, mac_clr=0, res_vld=0, res=0, res_id=0.
  - Round-robin pointer is set so requester 0 has priority.
  - The aborted operation produces no result.
- Operand zeroing: mac_ina = mac_inb = 0 in every state except on an accepted beat. The MAC accumulates every clock, so zero operands hold its value.
- IDLE:
  - No req: stay in IDLE.
  - Any req: grant the highest-priority requester under round-robin. After a grant to i, requester 1-i has priority next. If only one requests, it wins.
  - Latch len of the winner into a LEN_W-bit remaining counter and latch the id; go to CLEAR.
- CLEAR (exactly 1 cycle): mac_clr=1 and gnt asserted. Next state is DONE if the latched len==0, else RUN.
- RUN:
  - rdy[id]=1; rdy of the other requester is 0.
  - A beat is vld[id]&rdy[id]. On a beat: mac_ina/mac_inb = a_id/b_id combinationally, and the counter decrements.
  - vld low: no beat, operands zero; stalls are unbounded.
  - When the beat that brings the counter to 0 occurs, go to DONE.
- DONE (exactly 1 cycle):
  - res_vld=1, res=mac_out (which now includes the last beat), res_id=latched id.
  - Update the round-robin pointer, drop gnt, go to IDLE.
- res holds its value until the next DONE; res_vld is high only in DONE.
- Latency: grant decided in IDLE at cycle T; CLEAR at T+1; RUN from T+2. With vld held high for N pairs, beats occur at T+2..T+N+1 and res_vld at T+N+2. A back-to-back grant is possible at T+N+3.
- Arithmetic: the sum wraps modulo 2^16, with no saturation or overflow flag (matches the MAC).
- vld or operand changes from the non-granted requester are ignored. A requester dropping req mid-operation does not abort it; the result is still delivered.
- len changes after grant are ignored.

Decomposition:
- Shared package: state encoding constants (IDLE/CLEAR/RUN/DONE), RES_W=16, OP_W=8.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with priority-pointer register, request-in, one-hot grant-out and an advance strobe.
- Operand muxing and the FSM stay in mac_sched.

Test Plan:
- Single request: req=01, len0=2, pairs (3,4),(5,6) with vld held high → mac_clr pulse at T+1, res=0x002A, res_id=0, res_vld at T+4.
- Both request simultaneously after reset, len0=len1=1, req0 pair (2,2), req1 pair (7,3) → requester 0 first with res=0x0004; then requester 1 with res=0x0015, res_id=1. A third simultaneous round grants 0 again.
- Stall: req=10, len1=3, vld[1] toggling 1,0,0,1,0,1 with pairs (1,1),(2,2),(3,3) → exactly 3 beats, mac operands zero on stall cycles, res=0x000E.
- Overflow: len0=2, pairs (255,255),(255,255) → res=0xFC02 (130050 mod 65536).
- len0=0 → CLEAR then DONE, res=0x0000 at T+2, rdy never asserted.
- Reset mid-RUN after 1 of 3 beats → next cycle IDLE, all outputs 0. A fresh request then gives a correct result with no residue from the aborted accumulation.
